// File: rtl/down_counter_if.sv
// Control and status bundle for the down_counter interval timer.
// The master drives load/enable controls; the slave (the timer) reports count and flags.
interface down_counter_if #(
    parameter int COUNTER_WIDTH = 8
);
    logic                     load;
    logic [COUNTER_WIDTH-1:0] load_val;
    logic                     en;
    logic                     auto_rld;
    logic [COUNTER_WIDTH-1:0] cntr_o;
    logic                     tc_o;
    logic                     busy_o;
    logic                     done_o;

    modport master (
        output load, load_val, en, auto_rld,
        input  cntr_o, tc_o, busy_o, done_o
    );

    modport slave (
        input  load, load_val, en, auto_rld,
        output cntr_o, tc_o, busy_o, done_o
    );
endinterface

// File: rtl/down_counter.sv
// Loadable down-counter / interval timer with one-cycle terminal pulse,
// optional auto-reload and a sticky expiry flag.
//
// state | meaning
// IDLE  | not loaded, or loaded with zero
// RUN   | counting down on enabled cycles
// DONE  | expired without reload; count parked at zero
module down_counter #(
    parameter int COUNTER_WIDTH = 8
) (
    input  logic          clk,
    input  logic          rst,
    down_counter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [COUNTER_WIDTH-1:0] ONE  = {{(COUNTER_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [COUNTER_WIDTH-1:0] ZERO = '0;

    state_t                   state_q, state_d;
    logic [COUNTER_WIDTH-1:0] cntr_q,  cntr_d;
    logic [COUNTER_WIDTH-1:0] rld_q,   rld_d;
    logic                     tc_q,    tc_d;
    logic                     done_q,  done_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cntr_q  <= ZERO;
            rld_q   <= ZERO;
            tc_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cntr_q  <= cntr_d;
            rld_q   <= rld_d;
            tc_q    <= tc_d;
            done_q  <= done_d;
        end
    end

    // Load overrides everything, including a coincident terminal count.
    always_comb begin
        state_d = state_q;
        cntr_d  = cntr_q;
        rld_d   = rld_q;
        tc_d    = 1'b0;
        done_d  = done_q;

        if (bus.load) begin
            rld_d   = bus.load_val;
            cntr_d  = bus.load_val;
            done_d  = 1'b0;
            state_d = (bus.load_val != ZERO) ? RUN : IDLE;
        end else begin
            case (state_q)
                RUN: begin
                    if (bus.en) begin
                        if (cntr_q > ONE) begin
                            cntr_d = cntr_q - ONE;
                        end else begin
                            // Terminal: reload keeps the count from ever showing zero.
                            tc_d = 1'b1;
                            if (bus.auto_rld) begin
                                cntr_d = rld_q;
                            end else begin
                                cntr_d  = ZERO;
                                done_d  = 1'b1;
                                state_d = DONE;
                            end
                        end
                    end
                end
                IDLE, DONE: begin
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    assign bus.cntr_o = cntr_q;
    assign bus.tc_o   = tc_q;
    assign bus.busy_o = (state_q == RUN);
    assign bus.done_o = done_q;
endmodule
